// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared FSM state type and address-field width helpers for the
//               direct-mapped instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int c_word_w     = 32;
    localparam int c_byte_off_w = 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_lines, input int line_words);
        return addr_w - index_w(num_lines) - offset_w(line_words) - c_byte_off_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_dm_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_dm_array
// Description : Line storage: data words, tags and valid bits. Asynchronous
//               read, synchronous write, synchronous clear of all valid bits.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_dm_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 26
) (
    input  logic                              clk_i,
    input  logic [index_w(NUM_LINES)-1:0]     rd_idx_i,
    input  logic [offset_w(LINE_WORDS)-1:0]   rd_off_i,
    output logic [c_word_w-1:0]               rd_data_o,
    output logic [TAG_W-1:0]                  rd_tag_o,
    output logic                              rd_valid_o,
    input  logic                              wr_en_i,
    input  logic [index_w(NUM_LINES)-1:0]     wr_idx_i,
    input  logic [offset_w(LINE_WORDS)-1:0]   wr_off_i,
    input  logic [c_word_w-1:0]               wr_data_i,
    input  logic                              tag_we_i,
    input  logic [TAG_W-1:0]                  wr_tag_i,
    input  logic                              set_valid_i,
    input  logic                              clr_valid_i
);

    logic [c_word_w-1:0]  data_q [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;

    // Clear-all wins over a same-cycle set so a flush is never lost.
    always_comb begin
        valid_d = valid_q;
        if (set_valid_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
        if (clr_valid_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        valid_q <= valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        end
        if (tag_we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped instruction cache, zero-latency hit, word-by-word
//               line refill. Define ICACHE_DM_PERF_EN for hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_dm
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [31:0]       inst_o,
    output logic              valid_o,
    output logic              stall_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int c_off_w = offset_w(LINE_WORDS);
    localparam int c_idx_w = index_w(NUM_LINES);
    localparam int c_tag_w = tag_w(ADDR_W, NUM_LINES, LINE_WORDS);

    localparam logic [c_off_w-1:0] c_cnt_one  = c_off_w'(1);
    localparam logic [c_off_w-1:0] c_cnt_last = c_off_w'(LINE_WORDS - 1);

    state_e               state_q, state_d;
    logic [c_off_w-1:0]   cnt_q, cnt_d;
    logic [c_idx_w-1:0]   idx_q, idx_d;
    logic [c_tag_w-1:0]   tag_q, tag_d;
    logic                 pend_q, pend_d;

    logic [c_off_w-1:0]   w_req_off;
    logic [c_idx_w-1:0]   w_req_idx;
    logic [c_tag_w-1:0]   w_req_tag;
    logic                 w_unused_addr;
    logic [31:0]          w_rd_data;
    logic [c_tag_w-1:0]   w_rd_tag;
    logic                 w_rd_valid;
    logic                 w_hit;
    logic                 w_miss_start;
    logic                 w_ack;
    logic                 w_last;

    assign w_req_off     = cpu_addr_i[c_off_w+1:2];
    assign w_req_idx     = cpu_addr_i[c_off_w+2 +: c_idx_w];
    assign w_req_tag     = cpu_addr_i[ADDR_W-1 -: c_tag_w];
    assign w_unused_addr = ^cpu_addr_i[1:0];

    // A flush in the same cycle as a request forces a miss.
    assign w_hit = ~rst_i & (state_q == IDLE) & cpu_req_i & ~flush_i
                 & w_rd_valid & (w_rd_tag == w_req_tag);
    assign w_miss_start = ~rst_i & (state_q == IDLE) & cpu_req_i & ~w_hit;

    assign mem_req_o  = ~rst_i & (state_q == REFILL);
    assign mem_addr_o = {tag_q, idx_q, cnt_q, 2'b00};
    assign w_ack      = mem_req_o & mem_ack_i;
    assign w_last     = w_ack & (cnt_q == c_cnt_last);

    assign valid_o = w_hit;
    assign inst_o  = w_hit ? w_rd_data : 32'd0;
    assign stall_o = w_miss_start | mem_req_o;

    icache_dm_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (c_tag_w)
    ) u_array (
        .clk_i       (clk_i),
        .rd_idx_i    (w_req_idx),
        .rd_off_i    (w_req_off),
        .rd_data_o   (w_rd_data),
        .rd_tag_o    (w_rd_tag),
        .rd_valid_o  (w_rd_valid),
        .wr_en_i     (w_ack),
        .wr_idx_i    (idx_q),
        .wr_off_i    (cnt_q),
        .wr_data_i   (mem_data_i),
        .tag_we_i    (w_last),
        .wr_tag_i    (tag_q),
        .set_valid_i (w_last & ~pend_q & ~flush_i),
        .clr_valid_i (rst_i | flush_i)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (w_miss_start) begin
                    state_d = REFILL;
                    idx_d   = w_req_idx;
                    tag_d   = w_req_tag;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            REFILL: begin
                if (flush_i) begin
                    pend_d = 1'b1;
                end
                if (w_ack) begin
                    cnt_d = cnt_q + c_cnt_one;
                end
                if (w_last) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            idx_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
        end
    end

`ifdef ICACHE_DM_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (w_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (w_miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_dm
// Description : Self-checking bench for icache_dm with a line-level cache model
//               whose contents always mirror a synthetic backing memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_dm;

    localparam int c_nl = 16;
    localparam int c_lw = 4;
    localparam int c_lb = c_lw * 4;
`ifdef ICACHE_DM_PERF_EN
    localparam bit c_perf = 1'b1;
`else
    localparam bit c_perf = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i, cpu_req_i, flush_i, mem_ack_i;
    logic [31:0] cpu_addr_i, mem_data_i;
    logic [31:0] inst_o, mem_addr_o, hit_cnt_o, miss_cnt_o;
    logic        valid_o, stall_o, mem_req_o;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_total = 0;
    int stall_total = 0;
    int resp_wait = 0;
    bit junk_ack = 1'b0;
    logic [31:0] addr_q[$];

    bit          m_valid [c_nl];
    logic [31:0] m_base  [c_nl];
    bit          m_fill = 1'b0;
    bit          m_pend = 1'b0;
    logic [31:0] m_fill_base = '0;
    int          m_fill_idx = 0;
    int          m_acks = 0;
    logic [31:0] m_hits = '0;
    logic [31:0] m_misses = '0;

    always #5 clk = ~clk;

    icache_dm u_dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .cpu_req_i  (cpu_req_i),
        .cpu_addr_i (cpu_addr_i),
        .inst_o     (inst_o),
        .valid_o    (valid_o),
        .stall_o    (stall_o),
        .flush_i    (flush_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backing memory: optional wait states per word, spurious acks while idle.
    initial begin
        int rw;
        rw = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req_o && !rst_i) begin
                if (rw < resp_wait) begin
                    mem_ack_i  = 1'b0;
                    mem_data_i = 32'hDEAD_BEEF;
                    rw++;
                end else begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_word(mem_addr_o);
                    addr_q.push_back(mem_addr_o);
                    rw = 0;
                end
            end else begin
                mem_ack_i  = junk_ack;
                mem_data_i = 32'hDEAD_BEEF;
                rw = 0;
            end
        end
    end

    // Model + per-cycle comparison.
    always @(negedge clk) begin
        logic [31:0] a, base;
        int idx;
        bit eh;
        a    = {cpu_addr_i[31:2], 2'b00};
        base = a & ~32'(c_lb - 1);
        idx  = int'((a / c_lb) % c_nl);
        if (mem_req_o && mem_ack_i) ack_total++;
        if (stall_o) stall_total++;
        if (rst_i) begin
            chk("rst_valid_o", 32'(valid_o), 32'd0);
            chk("rst_stall_o", 32'(stall_o), 32'd0);
            chk("rst_mem_req_o", 32'(mem_req_o), 32'd0);
            chk("rst_inst_o", inst_o, 32'd0);
            for (int i = 0; i < c_nl; i++) m_valid[i] = 1'b0;
            m_fill = 1'b0; m_pend = 1'b0; m_hits = '0; m_misses = '0;
        end else begin
            chk("hit_cnt_o", hit_cnt_o, c_perf ? m_hits : 32'd0);
            chk("miss_cnt_o", miss_cnt_o, c_perf ? m_misses : 32'd0);
            if (!m_fill) begin
                eh = cpu_req_i && !flush_i && m_valid[idx] && (m_base[idx] == base);
                chk("valid_o", 32'(valid_o), 32'(eh));
                chk("stall_o", 32'(stall_o), 32'(cpu_req_i && !eh));
                chk("mem_req_o", 32'(mem_req_o), 32'd0);
                chk("inst_o", inst_o, eh ? mem_word(a) : 32'd0);
                if (eh) m_hits++;
                if (flush_i) for (int i = 0; i < c_nl; i++) m_valid[i] = 1'b0;
                if (cpu_req_i && !eh) begin
                    m_fill = 1'b1; m_fill_base = base; m_fill_idx = idx;
                    m_acks = 0; m_pend = 1'b0; m_misses++;
                end
            end else begin
                chk("refill_stall_o", 32'(stall_o), 32'd1);
                chk("refill_valid_o", 32'(valid_o), 32'd0);
                chk("refill_inst_o", inst_o, 32'd0);
                chk("refill_mem_req_o", 32'(mem_req_o), 32'd1);
                chk("refill_mem_addr_o", mem_addr_o, m_fill_base + 32'(4 * m_acks));
                if (flush_i) begin
                    for (int i = 0; i < c_nl; i++) m_valid[i] = 1'b0;
                    m_pend = 1'b1;
                end
                if (mem_ack_i) begin
                    m_acks++;
                    if (m_acks == c_lw) begin
                        m_fill = 1'b0;
                        if (!m_pend) begin
                            m_valid[m_fill_idx] = 1'b1;
                            m_base[m_fill_idx]  = m_fill_base;
                        end
                        m_pend = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_valid(output logic [31:0] inst);
        inst = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid_o) begin
                inst = inst_o;
                break;
            end
        end
        chk("fetch_valid", 32'(valid_o), 32'd1);
        @(posedge clk);
        #1 cpu_req_i = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, output logic [31:0] inst, output int stalls);
        int s0;
        @(posedge clk);
        #1 cpu_req_i = 1'b1;
        cpu_addr_i = a;
        s0 = stall_total;
        wait_valid(inst);
        stalls = stall_total - s0;
    endtask

    task automatic chk_line_addrs(input string name, input int q0, input logic [31:0] base);
        chk({name, "_nacks"}, 32'(addr_q.size() - q0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (q0 + k < addr_q.size()) chk({name, "_addr"}, addr_q[q0 + k], base + 32'(4 * k));
        end
    endtask

    initial begin
        logic [31:0] inst;
        int st, q0, a0, s0;
        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_addr_i = '0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        junk_ack = 1'b1;
        @(negedge clk);
        chk("reset_hit_cnt", hit_cnt_o, 32'd0);
        chk("reset_miss_cnt", miss_cnt_o, 32'd0);
        chk("reset_mem_req", 32'(mem_req_o), 32'd0);

        // Cold miss, then hit in the same line.
        q0 = addr_q.size();
        fetch(32'h0000_0104, inst, st);
        chk("cold_stalls", 32'(st), 32'd5);
        chk("cold_inst", inst, 32'hFEFB_0104);
        chk_line_addrs("cold", q0, 32'h0000_0100);
        fetch(32'h0000_010C, inst, st);
        chk("hit_stalls", 32'(st), 32'd0);
        chk("hit_inst", inst, 32'hFEF3_010C);
        chk("hit_cnt_lit", hit_cnt_o, c_perf ? 32'd2 : 32'd0);
        chk("miss_cnt_lit", miss_cnt_o, c_perf ? 32'd1 : 32'd0);

        // Conflict on index 0.
        q0 = addr_q.size();
        fetch(32'h0000_0500, inst, st);
        chk("conflict_stalls", 32'(st), 32'd5);
        chk("conflict_inst", inst, 32'hFAFF_0500);
        chk_line_addrs("conflict", q0, 32'h0000_0500);
        fetch(32'h0000_0100, inst, st);
        chk("conflict_back_stalls", 32'(st), 32'd5);
        chk("conflict_back_inst", inst, 32'hFEFF_0100);

        // Three wait states per word.
        resp_wait = 3;
        a0 = ack_total;
        fetch(32'h0000_0240, inst, st);
        chk("wait_stalls", 32'(st), 32'd17);
        chk("wait_acks", 32'(ack_total - a0), 32'd4);
        chk("wait_inst", inst, 32'hFDBF_0240);
        resp_wait = 0;

        // Flush after the second ack of a refill.
        @(posedge clk);
        #1 cpu_req_i = 1'b1;
        cpu_addr_i = 32'h0000_0208;
        s0 = stall_total; a0 = ack_total;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (ack_total - a0 >= 2) break;
        end
        #1 flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        wait_valid(inst);
        chk("flush_refill_stalls", 32'(stall_total - s0), 32'd10);
        chk("flush_refill_inst", inst, 32'hFDF7_0208);

        // Flush in IDLE together with a request.
        @(posedge clk);
        #1 cpu_req_i = 1'b1;
        cpu_addr_i = 32'h0000_020C;
        flush_i = 1'b1;
        s0 = stall_total;
        @(negedge clk);
        chk("flush_idle_stall", 32'(stall_o), 32'd1);
        @(posedge clk);
        #1 flush_i = 1'b0;
        wait_valid(inst);
        chk("flush_idle_stalls", 32'(stall_total - s0), 32'd5);
        chk("flush_idle_inst", inst, 32'hFDF3_020C);
        fetch(32'h0000_0240, inst, st);
        chk("flushed_line_stalls", 32'(st), 32'd5);
        fetch(32'h0000_0208, inst, st);
        chk("post_flush_hit_stalls", 32'(st), 32'd0);
        chk("post_flush_hit_inst", inst, 32'hFDF7_0208);

        // Reset after the first ack of a refill.
        @(posedge clk);
        #1 cpu_req_i = 1'b1;
        cpu_addr_i = 32'h0000_0304;
        a0 = ack_total;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (ack_total - a0 >= 1) break;
        end
        #1 rst_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_req", 32'(mem_req_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b0;
        s0 = stall_total;
        @(negedge clk);
        chk("rst_mid_hit_cnt", hit_cnt_o, 32'd0);
        chk("rst_mid_miss_cnt", miss_cnt_o, 32'd0);
        chk("rst_mid_retry_stall", 32'(stall_o), 32'd1);
        wait_valid(inst);
        chk("rst_mid_stalls", 32'(stall_total - s0), 32'd5);
        chk("rst_mid_inst", inst, 32'hFCFB_0304);
        chk("rst_mid_miss_cnt_after", miss_cnt_o, c_perf ? 32'd1 : 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter NUM_LINES, default 16, power of two >= 2, number of cache lines.
REQ-003 SHALL have parameter LINE_WORDS, default 4, power of two >= 2, 32-bit words per line.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have the following CPU-side ports:
- cpu_req_i  in  1  fetch request.
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] are ignored.
- inst_o  out  32  instruction word.
- valid_o  out  1  inst_o is valid this cycle.
- stall_o  out  1  request not served; CPU holds cpu_addr_i.
REQ-006 SHALL have the following control and memory-side ports:
- flush_i  in  1  invalidate all lines.
- mem_req_o  out  1  backing-memory word read request.
- mem_addr_o  out  ADDR_W  word-aligned read address.
- mem_ack_i  in  1  mem_data_i is valid; completes the current word.
- mem_data_i  in  32  read data.
REQ-007 SHALL have the following performance ports:
- hit_cnt_o  out  32  hit count.
- miss_cnt_o  out  32  miss count.

Function
REQ-008 SHALL split cpu_addr_i as follows:
- offset = [log2(LINE_WORDS)+1:2]
- index = next log2(NUM_LINES) bits
- tag = the remaining upper bits.
REQ-009 SHALL be direct-mapped, with per line: a valid bit, a tag, and LINE_WORDS data words.
REQ-010 SHALL decide a hit combinationally in IDLE: hit = cpu_req_i & valid[index] & (tag match).
REQ-011 SHALL, on a hit, drive valid_o=1, stall_o=0 and inst_o=data[index][offset] in the same cycle, with zero-latency lookup.
REQ-012 SHALL, whenever valid_o=0, drive inst_o=0.
REQ-013 SHALL use FSM states IDLE and REFILL.
REQ-014 SHALL, on cpu_req_i & ~hit in IDLE:
- assert stall_o combinationally;
- capture index and tag;
- clear the word counter;
- enter REFILL next cycle.
REQ-015 SHALL, in REFILL:
- hold stall_o=1 and valid_o=0;
- hold mem_req_o=1;
- drive mem_addr_o = {tag, index, counter, 2'b00}.
REQ-016 SHALL, on each mem_req_o & mem_ack_i, write mem_data_i to data[index][counter] and increment the counter; mem_req_o stays high for the next word.
REQ-017 SHALL, on the ack of word LINE_WORDS-1:
- write tag;
- set the valid bit;
- drop mem_req_o;
- return to IDLE;
- the retried request then hits.
REQ-018 SHALL NOT change mem_addr_o while mem_req_o=1 and mem_ack_i=0.
REQ-019 SHALL ignore mem_ack_i when mem_req_o=0.
REQ-020 SHALL, on flush_i in IDLE, clear all valid bits at the next edge; a request in the same cycle is treated as a miss.
REQ-021 SHALL, on flush_i during REFILL:
- clear all valid bits;
- set a pending flag;
- complete the refill without setting the refilled line's valid bit;
- then return to IDLE.
REQ-022 SHALL ignore cpu_addr_i changes during REFILL; the captured index and tag are used.
REQ-023 SHALL use wrapping arithmetic for the word counter, width log2(LINE_WORDS).

Reset
REQ-024 SHALL, with rst_i=1 at an edge:
- FSM=IDLE;
- all valid bits=0;
- counter=0;
- flush-pending flag=0;
- hit_cnt_o and miss_cnt_o=0.
REQ-025 SHALL, during reset, drive mem_req_o=0, valid_o=0, stall_o=0 and inst_o=0 from the first edge with rst_i=1.
REQ-026 SHALL, on reset asserted mid-REFILL, abort immediately; mem_req_o=0 next cycle, and a partial line is never marked valid.
REQ-027 SHALL NOT reset data and tag arrays.

Configuration
REQ-028 SHALL use macro ICACHE_DM_PERF_EN.
REQ-029 SHALL, when ICACHE_DM_PERF_EN is defined:
- increment hit_cnt_o on each cycle with valid_o=1;
- increment miss_cnt_o on each IDLE->REFILL transition;
- saturate both counters at 32'hFFFFFFFF.
REQ-030 SHALL, when ICACHE_DM_PERF_EN is undefined, tie hit_cnt_o and miss_cnt_o to 0 and omit the counter logic.

Structure
REQ-031 SHALL place in shared package icache_pkg:
- the FSM state enum (IDLE, REFILL);
- functions or constants for the offset, index and tag widths derived from the parameters.
REQ-032 SHALL implement line storage (data words plus tag and valid) in sub-module icache_dm_array, with asynchronous read, synchronous write and a synchronous clear-all-valid.

Verification
REQ-033 SHALL cover cold miss: with NUM_LINES=16, LINE_WORDS=4, request 0x00000104 -> stall_o=1; 4 mem requests at 0x100, 0x104, 0x108, 0x10C; then valid_o=1 with inst_o=word at 0x104.
REQ-034 SHALL cover hit after refill: request 0x0000010C -> same-cycle valid_o=1, no mem_req_o, hit_cnt_o +1 (with PERF_EN).
REQ-035 SHALL cover conflict: after filling 0x100, request 0x00000500 (same index 0, different tag) -> miss and refill at 0x500..0x50C; a later 0x100 misses again.
REQ-036 SHALL cover ack wait states: hold mem_ack_i=0 for 3 cycles per word -> mem_addr_o stable, 4 acks total, line valid only after the 4th.
REQ-037 SHALL cover flush during refill: flush_i after the 2nd ack -> refill finishes, and the retried request misses again.
REQ-038 SHALL cover reset mid-refill: rst_i after the 1st ack -> mem_req_o=0 next cycle, counters 0, and the next request to the same address misses.
